// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: datapath widths, the
// execute-command encodings and the hard-wired zero register address.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CMD_W  = 4;

    // Register 0 reads as zero and is never a real forwarding source.
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // Execute-stage ALU commands carried in the exe_cmd field.
    typedef enum logic [CMD_W-1:0] {
        EXE_NOP = 4'h0,
        EXE_MOV = 4'h1,
        EXE_ADD = 4'h2,
        EXE_SUB = 4'h3,
        EXE_AND = 4'h4,
        EXE_OR  = 4'h5,
        EXE_NOR = 4'h6,
        EXE_XOR = 4'h7,
        EXE_SLL = 4'h8,
        EXE_SRA = 4'h9,
        EXE_SRL = 4'hA
    } exe_cmd_e;

endpackage

// File: rtl/wb_bypass_mux.sv
// Same-cycle write-back bypass for one register-file read port. The register
// file only commits on the clock edge, so an operand being written this cycle
// must be taken from the write-back bus instead of the stale read data.
module wb_bypass_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] reg_val_i,
    input  logic              wb_write_en_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    input  logic [DATA_W-1:0] wb_val_i,
    output logic [DATA_W-1:0] op_o
);

    logic hit;

    // Address compare and value select; register 0 is never forwarded.
    always_comb begin
        hit  = wb_write_en_i && (wb_dest_i == src_i) && (wb_dest_i != REG_ZERO);
        op_o = hit ? wb_val_i : reg_val_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures the decoded instruction and its bypassed
// operands, inserts bubbles on flush or load-use hazard, and holds everything
// while frozen. hazard_stall tells IF/ID to hold their contents for a cycle.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CMD_W  = mips_pkg::CMD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              uses_src2,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic [DATA_W-1:0] reg1_in,
    input  logic [DATA_W-1:0] reg2_in,
    input  logic              wb_write_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_val,
    output logic              hazard_stall,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val1_out,
    output logic [DATA_W-1:0] val2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [CMD_W-1:0]  exe_cmd_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out
);

    // Operands after the write-back bypass.
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    // Stage state and next-state.
    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] pc_q,     pc_d;
    logic [DATA_W-1:0] val1_q,   val1_d;
    logic [DATA_W-1:0] val2_q,   val2_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [REG_AW-1:0] src1_q,   src1_d;
    logic [REG_AW-1:0] src2_q,   src2_d;
    logic [REG_AW-1:0] dest_q,   dest_d;
    logic [CMD_W-1:0]  cmd_q,    cmd_d;
    logic              mr_q,     mr_d;
    logic              mw_q,     mw_d;
    logic              wb_q,     wb_d;

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_bypass1 (
        .src_i         (src1),
        .reg_val_i     (reg1_in),
        .wb_write_en_i (wb_write_en),
        .wb_dest_i     (wb_dest),
        .wb_val_i      (wb_val),
        .op_o          (op1)
    );

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_bypass2 (
        .src_i         (src2),
        .reg_val_i     (reg2_in),
        .wb_write_en_i (wb_write_en),
        .wb_dest_i     (wb_dest),
        .wb_val_i      (wb_val),
        .op_o          (op2)
    );

    // Load-use detection: a load in EX whose result the decoding instruction
    // needs cannot be forwarded in time. A flush kills the decoding
    // instruction anyway, so it suppresses the stall request.
    always_comb begin
        hazard_stall = in_valid && valid_q && mr_q && (dest_q != REG_ZERO) &&
                       ((dest_q == src1) || (uses_src2 && (dest_q == src2))) &&
                       !flush;
    end

    // Next-state selection: hold when frozen, bubble on flush/hazard, else load.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        imm_d   = imm_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dest_d  = dest_q;
        cmd_d   = cmd_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        wb_d    = wb_q;
        if (!freeze) begin
            if (flush || hazard_stall) begin
                valid_d = 1'b0;
                pc_d    = '0;
                val1_d  = '0;
                val2_d  = '0;
                imm_d   = '0;
                src1_d  = '0;
                src2_d  = '0;
                dest_d  = '0;
                cmd_d   = '0;
                mr_d    = 1'b0;
                mw_d    = 1'b0;
                wb_d    = 1'b0;
            end else begin
                // Side-effecting enables are qualified by in_valid so an
                // empty decode slot always enters EX as a harmless bubble.
                valid_d = in_valid;
                pc_d    = pc_in;
                val1_d  = op1;
                val2_d  = op2;
                imm_d   = imm_in;
                src1_d  = src1;
                src2_d  = src2;
                dest_d  = dest_in;
                cmd_d   = exe_cmd_in;
                mr_d    = mem_r_en_in && in_valid;
                mw_d    = mem_w_en_in && in_valid;
                wb_d    = wb_en_in && in_valid;
            end
        end
    end

    // Pipeline register; reset clears everything so EX sees an empty slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            imm_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dest_q  <= '0;
            cmd_q   <= '0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            wb_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            imm_q   <= imm_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            dest_q  <= dest_d;
            cmd_q   <= cmd_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            wb_q    <= wb_d;
        end
    end

    // Registered outputs.
    always_comb begin
        valid_out    = valid_q;
        pc_out       = pc_q;
        val1_out     = val1_q;
        val2_out     = val2_q;
        imm_out      = imm_q;
        src1_out     = src1_q;
        src2_out     = src2_q;
        dest_out     = dest_q;
        exe_cmd_out  = cmd_q;
        mem_r_en_out = mr_q;
        mem_w_en_out = mw_q;
        wb_en_out    = wb_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX-slot contents are queued
// when decode stimulus is applied and compared after the clock edge.
module tb_id_ex_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] dest;
        logic [CMD_W-1:0]  cmd;
        logic              mr;
        logic              mw;
        logic              wb;
    } out_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze, flush, in_valid, uses_src2;
    logic [DATA_W-1:0] pc_in, imm_in, reg1_in, reg2_in, wb_val;
    logic [REG_AW-1:0] src1, src2, dest_in, wb_dest;
    logic [CMD_W-1:0]  exe_cmd_in;
    logic              mem_r_en_in, mem_w_en_in, wb_en_in, wb_write_en;
    logic              hazard_stall, valid_out;
    logic [DATA_W-1:0] pc_out, val1_out, val2_out, imm_out;
    logic [REG_AW-1:0] src1_out, src2_out, dest_out;
    logic [CMD_W-1:0]  exe_cmd_out;
    logic              mem_r_en_out, mem_w_en_out, wb_en_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sb[$];
    out_t exp_o, got_o;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .in_valid     (in_valid),
        .pc_in        (pc_in),
        .src1         (src1),
        .src2         (src2),
        .uses_src2    (uses_src2),
        .dest_in      (dest_in),
        .imm_in       (imm_in),
        .exe_cmd_in   (exe_cmd_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .wb_en_in     (wb_en_in),
        .reg1_in      (reg1_in),
        .reg2_in      (reg2_in),
        .wb_write_en  (wb_write_en),
        .wb_dest      (wb_dest),
        .wb_val       (wb_val),
        .hazard_stall (hazard_stall),
        .valid_out    (valid_out),
        .pc_out       (pc_out),
        .val1_out     (val1_out),
        .val2_out     (val2_out),
        .imm_out      (imm_out),
        .src1_out     (src1_out),
        .src2_out     (src2_out),
        .dest_out     (dest_out),
        .exe_cmd_out  (exe_cmd_out),
        .mem_r_en_out (mem_r_en_out),
        .mem_w_en_out (mem_w_en_out),
        .wb_en_out    (wb_en_out)
    );

    function automatic out_t sample();
        return {valid_out, pc_out, val1_out, val2_out, imm_out, src1_out,
                src2_out, dest_out, exe_cmd_out, mem_r_en_out, mem_w_en_out,
                wb_en_out};
    endfunction

    function automatic out_t mk(logic v, logic [DATA_W-1:0] pc, logic [DATA_W-1:0] v1,
                                logic [DATA_W-1:0] v2, logic [DATA_W-1:0] imm,
                                logic [REG_AW-1:0] s1, logic [REG_AW-1:0] s2,
                                logic [REG_AW-1:0] d, logic [CMD_W-1:0] cmd,
                                logic mr, logic mw, logic wb);
        return {v, pc, v1, v2, imm, s1, s2, d, cmd, mr, mw, wb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(logic iv, logic [DATA_W-1:0] pc, logic [REG_AW-1:0] s1,
                           logic [REG_AW-1:0] s2, logic u2, logic [REG_AW-1:0] d,
                           logic [DATA_W-1:0] imm, logic [CMD_W-1:0] cmd,
                           logic mr, logic mw, logic wb,
                           logic [DATA_W-1:0] r1, logic [DATA_W-1:0] r2);
        in_valid = iv; pc_in = pc; src1 = s1; src2 = s2; uses_src2 = u2;
        dest_in = d; imm_in = imm; exe_cmd_in = cmd;
        mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = wb;
        reg1_in = r1; reg2_in = r2;
    endtask

    task automatic set_wb(logic we, logic [REG_AW-1:0] d, logic [DATA_W-1:0] v);
        wb_write_en = we; wb_dest = d; wb_val = v;
    endtask

    task automatic drive_idle();
        set_dec(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_wb(1'b0, '0, '0);
        freeze = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        tick();
        tick();
        n_checks++;
        got_o = sample();
        if (got_o !== out_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", got_o);
        end
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hazard: got %b expected 0", hazard_stall);
        end
        rst = 1'b1;
    endtask

    task automatic test_normal_flow();
        set_dec(1'b1, 32'h40, 5'd3, 5'd4, 1'b1, 5'd7, 32'hFFFF_FFFC, EXE_ADD,
                1'b0, 1'b0, 1'b1, 32'h100, 32'h200);
        sb.push_back(mk(1'b1, 32'h40, 32'h100, 32'h200, 32'hFFFF_FFFC, 5'd3, 5'd4,
                        5'd7, EXE_ADD, 1'b0, 1'b0, 1'b1));
        #2;
        n_checks++;
        got_o = sample();
        if (got_o !== out_t'(0)) begin
            n_fail++;
            $display("FAIL normal_before_edge: got %h expected 0", got_o);
        end
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL normal_flow: got %h expected %h", got_o, exp_o);
        end
    endtask

    task automatic test_bypass();
        // src1 written back this cycle: take wb_val
        set_dec(1'b1, 32'h44, 5'd5, 5'd6, 1'b1, 5'd2, 32'h0, EXE_OR,
                1'b0, 1'b0, 1'b1, 32'h11, 32'h22);
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        sb.push_back(mk(1'b1, 32'h44, 32'hDEAD_BEEF, 32'h22, 32'h0, 5'd5, 5'd6,
                        5'd2, EXE_OR, 1'b0, 1'b0, 1'b1));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL bypass_src1: got %h expected %h", got_o, exp_o);
        end
        // register 0 is never bypassed
        set_dec(1'b1, 32'h48, 5'd0, 5'd6, 1'b1, 5'd2, 32'h0, EXE_OR,
                1'b0, 1'b0, 1'b1, 32'h11, 32'h22);
        set_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
        sb.push_back(mk(1'b1, 32'h48, 32'h11, 32'h22, 32'h0, 5'd0, 5'd6,
                        5'd2, EXE_OR, 1'b0, 1'b0, 1'b1));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL bypass_reg0: got %h expected %h", got_o, exp_o);
        end
        // src2 port bypass
        set_dec(1'b1, 32'h4C, 5'd1, 5'd9, 1'b1, 5'd3, 32'h0, EXE_SUB,
                1'b0, 1'b0, 1'b1, 32'h33, 32'h44);
        set_wb(1'b1, 5'd9, 32'hCAFE_0001);
        sb.push_back(mk(1'b1, 32'h4C, 32'h33, 32'hCAFE_0001, 32'h0, 5'd1, 5'd9,
                        5'd3, EXE_SUB, 1'b0, 1'b0, 1'b1));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL bypass_src2: got %h expected %h", got_o, exp_o);
        end
        // matching address without write enable: no bypass
        set_dec(1'b1, 32'h50, 5'd9, 5'd9, 1'b1, 5'd3, 32'h0, EXE_SUB,
                1'b0, 1'b0, 1'b1, 32'h55, 32'h66);
        set_wb(1'b0, 5'd9, 32'hCAFE_0002);
        sb.push_back(mk(1'b1, 32'h50, 32'h55, 32'h66, 32'h0, 5'd9, 5'd9,
                        5'd3, EXE_SUB, 1'b0, 1'b0, 1'b1));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL bypass_no_we: got %h expected %h", got_o, exp_o);
        end
        set_wb(1'b0, '0, '0);
    endtask

    task automatic test_load_use();
        // lw r8 enters EX
        set_dec(1'b1, 32'h60, 5'd2, 5'd0, 1'b0, 5'd8, 32'h10, EXE_ADD,
                1'b1, 1'b0, 1'b1, 32'h1000, 32'h0);
        sb.push_back(mk(1'b1, 32'h60, 32'h1000, 32'h0, 32'h10, 5'd2, 5'd0,
                        5'd8, EXE_ADD, 1'b1, 1'b0, 1'b1));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL loaduse_lw: got %h expected %h", got_o, exp_o);
        end
        // add r9, r1, r8 in decode depends on the load
        set_dec(1'b1, 32'h64, 5'd1, 5'd8, 1'b1, 5'd9, 32'h0, EXE_ADD,
                1'b0, 1'b0, 1'b1, 32'h10, 32'h20);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL loaduse_stall: got %b expected 1", hazard_stall);
        end
        sb.push_back(out_t'(0));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL loaduse_bubble: got %h expected %h", got_o, exp_o);
        end
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL loaduse_release: got %b expected 0", hazard_stall);
        end
        sb.push_back(mk(1'b1, 32'h64, 32'h10, 32'h20, 32'h0, 5'd1, 5'd8,
                        5'd9, EXE_ADD, 1'b0, 1'b0, 1'b1));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL loaduse_add: got %h expected %h", got_o, exp_o);
        end
    endtask

    task automatic test_no_false_hazard();
        set_dec(1'b1, 32'h70, 5'd2, 5'd0, 1'b0, 5'd8, 32'h0, EXE_ADD,
                1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        tick();
        // src2 matches but is not read
        set_dec(1'b1, 32'h74, 5'd3, 5'd8, 1'b0, 5'd9, 32'h0, EXE_ADD,
                1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nohaz_unused_src2: got %b expected 0", hazard_stall);
        end
        // real dependency but flush in progress
        src1  = 5'd8;
        flush = 1'b1;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nohaz_flush: got %b expected 0", hazard_stall);
        end
        flush = 1'b0;
        // real dependency but decode slot empty
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nohaz_invalid: got %b expected 0", hazard_stall);
        end
        // load targeting r0
        set_dec(1'b1, 32'h78, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0, EXE_ADD,
                1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        tick();
        set_dec(1'b1, 32'h7C, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0, EXE_ADD,
                1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nohaz_dest0: got %b expected 0", hazard_stall);
        end
    endtask

    task automatic test_flush_freeze();
        out_t held;
        // store in EX
        set_dec(1'b1, 32'h80, 5'd4, 5'd5, 1'b1, 5'd0, 32'h8, EXE_ADD,
                1'b0, 1'b1, 1'b0, 32'hAA, 32'hBB);
        held = mk(1'b1, 32'h80, 32'hAA, 32'hBB, 32'h8, 5'd4, 5'd5,
                  5'd0, EXE_ADD, 1'b0, 1'b1, 1'b0);
        sb.push_back(held);
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL ff_store: got %h expected %h", got_o, exp_o);
        end
        // freeze overrides flush
        set_dec(1'b1, 32'h84, 5'd6, 5'd7, 1'b1, 5'd0, 32'hC, EXE_ADD,
                1'b0, 1'b1, 1'b0, 32'hCC, 32'hDD);
        freeze = 1'b1;
        flush  = 1'b1;
        sb.push_back(held);
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL ff_freeze_hold: got %h expected %h", got_o, exp_o);
        end
        freeze = 1'b0;
        sb.push_back(out_t'(0));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL ff_flush_bubble: got %h expected %h", got_o, exp_o);
        end
        n_checks++;
        if (mem_w_en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_flush_memw: got %b expected 0", mem_w_en_out);
        end
        flush = 1'b0;
        // freeze overrides a load-use hazard too
        set_dec(1'b1, 32'h90, 5'd2, 5'd0, 1'b0, 5'd8, 32'h4, EXE_ADD,
                1'b1, 1'b0, 1'b1, 32'h77, 32'h0);
        held = mk(1'b1, 32'h90, 32'h77, 32'h0, 32'h4, 5'd2, 5'd0,
                  5'd8, EXE_ADD, 1'b1, 1'b0, 1'b1);
        tick();
        set_dec(1'b1, 32'h94, 5'd8, 5'd1, 1'b1, 5'd9, 32'h0, EXE_SUB,
                1'b0, 1'b0, 1'b1, 32'h1, 32'h2);
        freeze = 1'b1;
        sb.push_back(held);
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL ff_freeze_hazard: got %h expected %h", got_o, exp_o);
        end
        freeze = 1'b0;
        sb.push_back(out_t'(0));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL ff_unfreeze_bubble: got %h expected %h", got_o, exp_o);
        end
    endtask

    task automatic test_invalid_slot();
        set_dec(1'b0, 32'hA0, 5'd1, 5'd2, 1'b1, 5'd3, 32'h5, EXE_XOR,
                1'b1, 1'b1, 1'b1, 32'h9, 32'hA);
        sb.push_back(mk(1'b0, 32'hA0, 32'h9, 32'hA, 32'h5, 5'd1, 5'd2,
                        5'd3, EXE_XOR, 1'b0, 1'b0, 1'b0));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL invalid_slot: got %h expected %h", got_o, exp_o);
        end
    endtask

    task automatic test_reset_midstream();
        set_dec(1'b1, 32'hB0, 5'd1, 5'd2, 1'b1, 5'd4, 32'h0, EXE_ADD,
                1'b0, 1'b0, 1'b1, 32'h5, 32'h6);
        sb.push_back(mk(1'b1, 32'hB0, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2,
                        5'd4, EXE_ADD, 1'b0, 1'b0, 1'b1));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL midrst_loaded: got %h expected %h", got_o, exp_o);
        end
        #2;
        rst = 1'b0;
        #1;
        got_o = sample();
        n_checks++;
        if (got_o !== out_t'(0)) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got %h expected 0", got_o);
        end
        #1;
        rst = 1'b1;
        drive_idle();
    endtask

    task automatic test_back_to_back();
        out_t cur, nxt;
        logic [DATA_W-1:0] m1, m2;
        logic hz;
        // start from a known empty slot
        flush = 1'b1;
        sb.push_back(out_t'(0));
        tick();
        exp_o = sb.pop_front();
        got_o = sample();
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL b2b_start: got %h expected %h", got_o, exp_o);
        end
        cur = out_t'(0);
        for (int i = 0; i < 60; i++) begin
            set_dec(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                    $urandom, 4'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
                    1'($urandom), $urandom, $urandom);
            set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            freeze = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            #1;
            m1 = (wb_write_en && wb_dest == src1 && wb_dest != 0) ? wb_val : reg1_in;
            m2 = (wb_write_en && wb_dest == src2 && wb_dest != 0) ? wb_val : reg2_in;
            hz = in_valid && cur.valid && cur.mr && cur.dest != 0 &&
                 (cur.dest == src1 || (uses_src2 && cur.dest == src2)) && !flush;
            n_checks++;
            if (hazard_stall !== hz) begin
                n_fail++;
                $display("FAIL b2b_hazard[%0d]: got %b expected %b", i, hazard_stall, hz);
            end
            if (freeze)
                nxt = cur;
            else if (flush || hz)
                nxt = out_t'(0);
            else
                nxt = mk(in_valid, pc_in, m1, m2, imm_in, src1, src2, dest_in,
                         exe_cmd_in, mem_r_en_in & in_valid, mem_w_en_in & in_valid,
                         wb_en_in & in_valid);
            sb.push_back(nxt);
            tick();
            exp_o = sb.pop_front();
            got_o = sample();
            n_checks++;
            if (got_o !== exp_o) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got %h expected %h", i, got_o, exp_o);
            end
            cur = nxt;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_normal_flow();
        test_bypass();
        test_load_use();
        test_no_false_hazard();
        test_flush_freeze();
        test_invalid_slot();
        test_reset_midstream();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
